// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier dispatch slice:
// dispatcher FSM state encoding and FIFO width helpers.
package booth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_LO,
        WAIT_HI,
        DRAIN
    } state_t;

    localparam int DEF_DATAWIDTH = 32;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_TAGW      = 4;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/booth_op_fifo.sv
// Operand FIFO: DEPTH entries of WIDTH bits, pointers wrap mod DEPTH.
// Ports: clk, rstn, push/wdata, pop/rdata (head), count, full, empty.
module booth_op_fifo
    import booth_pkg::*;
#(
    parameter int WIDTH = 68,
    parameter int DEPTH = DEF_DEPTH,
    localparam int PW   = ptr_w(DEPTH),
    localparam int CW   = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !do_pop)
                count <= count + CW'(1);
            else if (do_pop && !do_push)
                count <= count - CW'(1);
        end
    end

    // Storage needs no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/booth_dispatch.sv
// Queues tagged operand pairs and feeds them one at a time to booth_fsm,
// returning registered products in order. Ports: in_* (push side),
// mul_* (booth_fsm handshake), out_* (result side), count (occupancy).
module booth_dispatch
    import booth_pkg::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int TAGW      = DEF_TAGW
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATAWIDTH-1:0]   in_a,
    input  logic [DATAWIDTH-1:0]   in_b,
    input  logic [TAGW-1:0]        in_tag,
    output logic                   mul_en,
    output logic [DATAWIDTH-1:0]   mul_multiplier,
    output logic [DATAWIDTH-1:0]   mul_multiplicand,
    input  logic                   mul_done,
    input  logic [2*DATAWIDTH-1:0] mul_product,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*DATAWIDTH-1:0] out_product,
    output logic [TAGW-1:0]        out_tag,
    output logic [$clog2(DEPTH):0] count
);

    localparam int EW = 2 * DATAWIDTH + TAGW;

    state_t                 state;
    logic [EW-1:0]          head;
    logic [TAGW-1:0]        op_tag;
    logic                   full;
    logic                   empty;
    logic                   pop;
    logic                   capture;

    assign in_ready = !full;
    assign pop      = (state == IDLE) && !empty;
    // Result register frees up this cycle if empty or being consumed.
    assign capture  = (state == DRAIN) && (!out_valid || out_ready);

    booth_op_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (in_valid),
        .wdata ({in_a, in_b, in_tag}),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= IDLE;
            mul_en           <= 1'b0;
            mul_multiplier   <= '0;
            mul_multiplicand <= '0;
            op_tag           <= '0;
            out_valid        <= 1'b0;
            out_product      <= '0;
            out_tag          <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        mul_multiplier   <= head[EW-1 -: DATAWIDTH];
                        mul_multiplicand <= head[TAGW +: DATAWIDTH];
                        op_tag           <= head[TAGW-1:0];
                        mul_en           <= 1'b1;
                        state            <= START;
                    end
                end
                START: begin
                    mul_en <= 1'b0;
                    state  <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!mul_done)
                        state <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (mul_done)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (capture) begin
                        out_product <= mul_product;
                        out_tag     <= op_tag;
                        out_valid   <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    mul_en <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/booth_dispatch.md
BOOTH_DISPATCH -- requirements
Module: booth_dispatch

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, operand width passed to booth_fsm.
REQ-002 SHALL have parameter DEPTH, default 4, operand FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter TAGW, default 4, width of the caller tag carried with each operation.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  operand pair offered.
REQ-007 in_ready  output  1  FIFO can accept; high when count<DEPTH.
REQ-008 in_a  input  DATAWIDTH  multiplier (signed two's complement).
REQ-009 in_b  input  DATAWIDTH  multiplicand (signed two's complement).
REQ-010 in_tag  input  TAGW  caller tag.
REQ-011 mul_en  output  1  start request to booth_fsm.
REQ-012 mul_multiplier  output  DATAWIDTH  operand A to booth_fsm, held stable from START until capture.
REQ-013 mul_multiplicand  output  DATAWIDTH  operand B to booth_fsm, held stable likewise.
REQ-014 mul_done  input  1  booth_fsm done; low while computing, high when product valid.
REQ-015 mul_product  input  2*DATAWIDTH  signed product from booth_fsm.
REQ-016 out_valid  output  1  result register holds a result.
REQ-017 out_ready  input  1  consumer accepts result.
REQ-018 out_product  output  2*DATAWIDTH  registered signed product.
REQ-019 out_tag  output  TAGW  tag of that product.
REQ-020 count  output  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-021 SHALL push {in_a,in_b,in_tag} into FIFO on cycles where in_valid&&in_ready; push and pop in the same cycle leave count unchanged.
REQ-022 SHALL ignore in_valid when count==DEPTH; no overwrite, no pointer move.
REQ-023 FSM states: IDLE, START, WAIT_LO, WAIT_HI, DRAIN.
REQ-024 IDLE -> START when count>0; pop FIFO head into operand registers on that transition.
REQ-025 START: mul_en=1 for exactly one cycle, then -> WAIT_LO; mul_en SHALL be 0 in every other state.
REQ-026 WAIT_LO -> WAIT_HI when mul_done==0 (booth_fsm acknowledged start).
REQ-027 WAIT_HI -> DRAIN when mul_done==1.
REQ-028 DRAIN: when out_valid==0 or out_ready==1, capture mul_product and the operation's tag into output registers, set out_valid, -> IDLE; otherwise remain in DRAIN.
REQ-029 out_valid SHALL clear on out_valid&&out_ready unless a DRAIN capture occurs in the same cycle, in which case it stays 1 with new data.
REQ-030 Results SHALL leave in FIFO push order; at most one operation in booth_fsm at a time.
REQ-031 out_product/out_tag SHALL hold stable while out_valid&&!out_ready.
REQ-032 FIFO pointers SHALL wrap modulo DEPTH; full/empty derived from count.
REQ-033 Latency from push into empty idle block to out_valid: 3 cycles plus booth_fsm compute time.

Reset
REQ-034 rstn low SHALL immediately force IDLE, count=0, pointers=0, in_ready=1, mul_en=0, out_valid=0, out_product=0, out_tag=0, operand registers=0.
REQ-035 Reset mid-operation SHALL discard all queued and in-flight operations; no result emitted for them after release.

Structure
REQ-036 FSM state encoding and DEPTH-derived widths SHALL live in shared package booth_pkg.
REQ-037 FIFO SHALL be a sub-module booth_op_fifo (storage, pointers, count); FSM and output register in booth_dispatch.

Verification
REQ-038 Single op: push a=3,b=-5,tag=1 with out_ready=1 -> one out_valid with out_product=-15, out_tag=1.
REQ-039 Extremes: push a=0x80000000,b=0x80000000 then a=0x7FFFFFFF,b=0xFFFFFFFF -> products 0x4000000000000000 then 0xFFFFFFFF80000001, in order.
REQ-040 Full: out_ready=0, push 6 ops back-to-back -> in_ready low once count==4 (plus one in flight); no entry lost or duplicated after out_ready=1; tags 0..5 emitted in order.
REQ-041 Backpressure: out_ready=0 while result pending -> FSM holds DRAIN, out_product stable, mul_en stays 0 until out_ready=1.
REQ-042 Simultaneous push/pop at count==2 -> count stays 2; push at full ignored.
REQ-043 Reset mid-operation in WAIT_HI with 3 queued -> outputs to reset values immediately; after release and no new pushes, out_valid never asserts.
